edge_event_counter: RTL and testbench
=====================================

Name: edge_event_counter

Overview:
- Parametrised successor to the two-input, 2-bit-output DUV.
- Takes NCH asynchronous single-bit inputs and runs each through a SYNC_STAGES-deep synchroniser.
- Detects rising, falling or both edges per a runtime mode, pulses a per-channel event flag, and keeps a per-channel CNT_W-bit event counter with wrap or saturate behaviour and a sticky overflow flag.
- Sits directly under SIM_TOP-style benches as the DUV for multi-channel stimulus.

Parameters:
- NCH, 2, number of input channels (>=1).
- CNT_W, 2, per-channel counter width (>=1).
- SYNC_STAGES, 2, synchroniser flops per channel (>=2).
- SATURATE, 0, 0 = counter wraps to 0 past max; 1 = counter holds at 2^CNT_W-1.

Ports:
- clk, in, 1, single clock; all logic on rising edge.
- arst, in, 1, asynchronous active-low reset; asserted when 0, takes effect immediately, release is synchronous to clk.
- en, in, 1, counting enable; edge detection still runs when low.
- clr, in, 1, synchronous clear of all counters and overflow flags.
- mode, in, 2, 00 off, 01 rise, 10 fall, 11 both.
- din, in, NCH, asynchronous channel inputs.
- evt, out, NCH, one-cycle event pulse per channel.
- cnt, out, NCH*CNT_W, counters; channel i at [i*CNT_W +: CNT_W].
- ovf, out, NCH, sticky overflow per channel.
- any_evt, out, 1, OR of evt (registered alongside evt).
- ready, out, 1, high once FSM is in RUN.

Behaviour:
- Reset (arst=0): all synchroniser flops, history flops, evt, cnt, ovf, any_evt and ready go to 0. FSM goes to INIT with init counter 0.
- FSM:
  - INIT counts SYNC_STAGES+1 clock edges after reset release while the synchronisers and history registers fill. evt is forced to 0 and counters are frozen.
  - INIT -> RUN on the edge the init count reaches SYNC_STAGES; ready=1 from the following cycle. RUN is held until reset.
  - clr does not leave RUN and does not re-enter INIT.
- Synchroniser: s[0] samples din; s[k] samples s[k-1]. hist holds the previous s[SYNC_STAGES-1].
- Edge decode, in RUN only:
  - rise = s_last & ~hist; fall = ~s_last & hist.
  - Per mode: 01 → rise, 10 → fall, 11 → rise|fall, 00 → none.
- Latency: a din level change first captured by s[0] at edge T0 produces evt=1 after edge T0+SYNC_STAGES, lasting exactly one cycle. With SYNC_STAGES=2, evt is high in cycle 3 after the capturing edge.
- Counters update on the same edge that raises evt, when en=1:
  - SATURATE=0: cnt+1 modulo 2^CNT_W. Wrap from max to 0 sets ovf.
  - SATURATE=1: at max, cnt holds; an event at max sets ovf.
  - With en=0, evt still pulses but cnt and ovf hold.
- clr=1: on that edge cnt<=0 and ovf<=0 for all channels, overriding any simultaneous increment; that event is lost from the count but evt still pulses. clr during INIT clears harmlessly.
- Mode change takes effect for edges decoded on the next clock edge. Changing mode never generates an event by itself.
- Channels are fully independent; simultaneous events on several channels each count.
- din pulses shorter than one clk period may be missed; not an error.
- Reset mid-operation: arst low at any time returns everything to reset values immediately, followed by a full INIT on release. No event is produced from pre-reset history.
- Width rules: counters are unsigned; no cross-channel carry.

Test Plan:
- Reset/INIT, NCH=2, CNT_W=2, SYNC_STAGES=2: arst low 2 cycles, then release with din=2'b11 held → evt stays 0 throughout INIT, ready rises 4 cycles after release, cnt=0, no spurious rise event.
- Rise mode, en=1, mode=01: din[0] 0→1 → evt[0]=1 for one cycle, 3 cycles after capture; cnt[1:0]=1; channel 1 unchanged. Then 1→0 → no evt, cnt stays 1.
- Both mode wrap, SATURATE=0: 4 edges on din[1] (2 pulses) → cnt[3:2] steps 1,2,3,0; ovf[1]=1 on the 4th event and stays 1.
- Saturate, SATURATE=1, mode=11: 5 edges on din[0] → cnt[1:0] reaches 3 and holds at 3; ovf[0] sets on the 4th event.
- en/clr interplay: en=0 with 2 rises → evt pulses twice, cnt unchanged. Then en=1 with clr asserted on the same cycle as an evt → cnt=0, ovf=0, evt still seen.
- Reset mid-count: cnt[1:0]=2, assert arst for 1 cycle between edges → all outputs 0 immediately, INIT re-runs, counting resumes from 0.

Source files
------------

// File: rtl/edge_event_counter.sv
// edge_event_counter: per-channel synchronised edge detector with event pulses, wrap/saturate counters and sticky overflow
module edge_event_counter #(
  parameter int NCH         = 2,
  parameter int CNT_W       = 2,
  parameter int SYNC_STAGES = 2,
  parameter int SATURATE    = 0
) (
  input  logic                   clk,
  input  logic                   arst,
  input  logic                   en,
  input  logic                   clr,
  input  logic [1:0]             mode,
  input  logic [NCH-1:0]         din,
  output logic [NCH-1:0]         evt,
  output logic [NCH*CNT_W-1:0]   cnt,
  output logic [NCH-1:0]         ovf,
  output logic                   any_evt,
  output logic                   ready
);
  localparam int IW = $clog2(SYNC_STAGES + 1);
  typedef enum logic {INIT, RUN} state_t;
  state_t state, state_d;
  logic [IW-1:0] init_cnt, init_cnt_d;
  logic [SYNC_STAGES-1:0][NCH-1:0] s;
  logic [NCH-1:0] hist, rise, fall, ev, ovf_d;
  logic [NCH-1:0][CNT_W-1:0] cnt_r, cnt_d;
  always_ff @(posedge clk or negedge arst)
    if (!arst) begin
      state    <= INIT;
      init_cnt <= '0;
    end else begin
      state    <= state_d;
      init_cnt <= init_cnt_d;
    end
  // INIT lasts SYNC_STAGES+1 edges so synchronisers and history hold real samples before decoding
  always_comb begin
    state_d    = state;
    init_cnt_d = init_cnt;
    if (state == INIT) begin
      state_d    = (init_cnt == IW'(SYNC_STAGES)) ? RUN : INIT;
      init_cnt_d = (init_cnt == IW'(SYNC_STAGES)) ? init_cnt : init_cnt + 1'b1;
    end
  end
  assign rise = s[SYNC_STAGES-1] & ~hist;
  assign fall = ~s[SYNC_STAGES-1] & hist;
  assign ev   = (state == RUN) ? (({NCH{mode[0]}} & rise) | ({NCH{mode[1]}} & fall)) : '0;
  // clear wins over a simultaneous increment; the event still pulses
  always_comb begin
    cnt_d = cnt_r;
    ovf_d = ovf;
    for (int i = 0; i < NCH; i++)
      if (ev[i] && en) begin
        cnt_d[i] = (SATURATE != 0 && &cnt_r[i]) ? cnt_r[i] : cnt_r[i] + 1'b1;
        ovf_d[i] = ovf[i] | (&cnt_r[i]);
      end
    if (clr) begin
      cnt_d = '0;
      ovf_d = '0;
    end
  end
  always_ff @(posedge clk or negedge arst)
    if (!arst) begin
      s       <= '0;
      hist    <= '0;
      evt     <= '0;
      cnt_r   <= '0;
      ovf     <= '0;
      any_evt <= 1'b0;
      ready   <= 1'b0;
    end else begin
      s       <= {s[SYNC_STAGES-2:0], din};
      hist    <= s[SYNC_STAGES-1];
      evt     <= ev;
      cnt_r   <= cnt_d;
      ovf     <= ovf_d;
      any_evt <= |ev;
      ready   <= (state == RUN);
    end
  assign cnt = cnt_r;
endmodule

// File: tb/tb_edge_event_counter.sv
// tb_edge_event_counter: directed vectors against a wrapping and a saturating instance sharing one stimulus
module tb_edge_event_counter;
  logic clk = 1'b0, arst = 1'b0, en = 1'b1, clr = 1'b0;
  logic [1:0] mode = 2'b01, din = 2'b00;
  logic [1:0] evt, ovf, evt_s, ovf_s;
  logic [3:0] cnt, cnt_s;
  logic any_evt, ready, any_evt_s, ready_s;
  int vectors = 0, errors = 0;
  always #5 clk = ~clk;
  edge_event_counter #(.NCH(2), .CNT_W(2), .SYNC_STAGES(2), .SATURATE(0)) dut (
    .clk(clk), .arst(arst), .en(en), .clr(clr), .mode(mode), .din(din),
    .evt(evt), .cnt(cnt), .ovf(ovf), .any_evt(any_evt), .ready(ready));
  edge_event_counter #(.NCH(2), .CNT_W(2), .SYNC_STAGES(2), .SATURATE(1)) dut_s (
    .clk(clk), .arst(arst), .en(en), .clr(clr), .mode(mode), .din(din),
    .evt(evt_s), .cnt(cnt_s), .ovf(ovf_s), .any_evt(any_evt_s), .ready(ready_s));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  // new level is captured on the first edge; evt is high after the third
  task automatic edge_seq(input logic [1:0] d, input logic [1:0] e);
    din = d;
    tick();
    tick();
    chk("evt_early", evt, 2'b00);
    tick();
    chk("evt", evt, e);
    chk("evt_s", evt_s, e);
    chk("any_evt", any_evt, |e);
    tick();
    chk("evt_after", evt, 2'b00);
  endtask
  task automatic init_seq(input string tag);
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk({tag, "_ready_lo"}, ready, 1'b0);
      chk({tag, "_evt_init"}, evt, 2'b00);
    end
    tick();
    chk({tag, "_ready_hi"}, ready, 1'b1);
    chk({tag, "_ready_s_hi"}, ready_s, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk({tag, "_no_spurious"}, evt, 2'b00);
    end
    chk({tag, "_cnt"}, cnt, 4'h0);
  endtask
  initial begin
    tick();
    tick();
    chk("rst_evt", evt, 2'b00);
    chk("rst_cnt", cnt, 4'h0);
    chk("rst_ovf", ovf, 2'b00);
    chk("rst_ready", ready, 1'b0);
    chk("rst_any", any_evt, 1'b0);
    din = 2'b11;
    arst = 1'b1;
    init_seq("init");
    edge_seq(2'b00, 2'b00);
    edge_seq(2'b01, 2'b01);
    chk("rise_cnt", cnt, 4'b0001);
    edge_seq(2'b00, 2'b00);
    chk("rise_fall_cnt", cnt, 4'b0001);
    mode = 2'b11;
    edge_seq(2'b10, 2'b10);
    chk("wrap_c1", cnt, 4'b0101);
    edge_seq(2'b00, 2'b10);
    chk("wrap_c2", cnt, 4'b1001);
    edge_seq(2'b10, 2'b10);
    chk("wrap_c3", cnt, 4'b1101);
    chk("wrap_ovf3", ovf, 2'b00);
    edge_seq(2'b00, 2'b10);
    chk("wrap_c0", cnt, 4'b0001);
    chk("wrap_ovf", ovf, 2'b10);
    chk("sat_hold_c1", cnt_s, 4'b1101);
    chk("sat_ovf_c1", ovf_s, 2'b10);
    tick();
    tick();
    chk("ovf_sticky", ovf, 2'b10);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("clr_cnt", cnt, 4'h0);
    chk("clr_ovf", ovf, 2'b00);
    chk("clr_cnt_s", cnt_s, 4'h0);
    chk("clr_ready", ready, 1'b1);
    edge_seq(2'b01, 2'b01);
    chk("sat1", cnt_s, 4'b0001);
    edge_seq(2'b00, 2'b01);
    chk("sat2", cnt_s, 4'b0010);
    edge_seq(2'b01, 2'b01);
    chk("sat3", cnt_s, 4'b0011);
    chk("sat3_ovf", ovf_s, 2'b00);
    edge_seq(2'b00, 2'b01);
    chk("sat4", cnt_s, 4'b0011);
    chk("sat4_ovf", ovf_s, 2'b01);
    chk("wrap4", cnt, 4'b0000);
    chk("wrap4_ovf", ovf, 2'b01);
    edge_seq(2'b01, 2'b01);
    chk("sat5", cnt_s, 4'b0011);
    chk("sat5_ovf", ovf_s, 2'b01);
    chk("wrap5", cnt, 4'b0001);
    mode = 2'b01;
    en = 1'b0;
    edge_seq(2'b00, 2'b00);
    edge_seq(2'b01, 2'b01);
    edge_seq(2'b00, 2'b00);
    edge_seq(2'b01, 2'b01);
    chk("en0_cnt", cnt, 4'b0001);
    chk("en0_ovf", ovf, 2'b01);
    chk("en0_cnt_s", cnt_s, 4'b0011);
    en = 1'b1;
    din = 2'b00;
    for (int i = 0; i < 4; i++) tick();
    din = 2'b01;
    tick();
    tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("clr_evt", evt, 2'b01);
    chk("clr_evt_cnt", cnt, 4'h0);
    chk("clr_evt_ovf", ovf, 2'b00);
    chk("clr_evt_cnt_s", cnt_s, 4'h0);
    chk("clr_evt_ovf_s", ovf_s, 2'b00);
    tick();
    edge_seq(2'b00, 2'b00);
    edge_seq(2'b01, 2'b01);
    edge_seq(2'b00, 2'b00);
    edge_seq(2'b01, 2'b01);
    chk("pre_rst_cnt", cnt, 4'b0010);
    arst = 1'b0;
    #1;
    chk("mid_rst_cnt", cnt, 4'h0);
    chk("mid_rst_ready", ready, 1'b0);
    chk("mid_rst_ovf", ovf_s, 2'b00);
    tick();
    arst = 1'b1;
    init_seq("reinit");
    edge_seq(2'b00, 2'b00);
    edge_seq(2'b01, 2'b01);
    chk("resume_cnt", cnt, 4'b0001);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
